// File: rtl/weight_update_feeder.sv
// Fetches float16 kernels one at a time from a source memory and packs PARA_KERNEL
// of them per weight-RAM slice, driving the conv engine's weight write interface.
module weight_update_feeder #(
  parameter int unsigned DATA_WIDTH              = 16,
  parameter int unsigned KERNEL_SIZE_MAX         = 3,
  parameter int unsigned PARA_KERNEL             = 2,
  parameter int unsigned WEIGHT_WRITE_ADDR_WIDTH = 10,
  parameter int unsigned SRC_ADDR_WIDTH          = 16,
  parameter int unsigned UPDATE_SLICES           = 2,
  parameter int unsigned SLICE_CNT_WIDTH         = 8
) (
  input  logic                                                                 clk,
  input  logic                                                                 rst,
  input  logic                                                                 load_start,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH-1:0]                                   load_addr,
  input  logic [SLICE_CNT_WIDTH-1:0]                                           load_slices,
  input  logic [SRC_ADDR_WIDTH-1:0]                                            load_src_addr,
  input  logic                                                                 update_weight_ram,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                       update_weight_ram_addr,
  output logic                                                                 src_rd_req,
  output logic [SRC_ADDR_WIDTH-1:0]                                            src_rd_addr,
  input  logic                                                                 src_rd_valid,
  input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0]                src_rd_data,
  output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0]    weight_data,
  output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                       write_weight_data_addr,
  output logic                                                                 weight_data_done,
  output logic                                                                 busy
);

  localparam int unsigned K2  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int unsigned KW  = K2 * DATA_WIDTH;
  localparam int unsigned SW  = KW * PARA_KERNEL;
  localparam int unsigned AW  = WEIGHT_WRITE_ADDR_WIDTH;
  localparam int unsigned WAW = WEIGHT_WRITE_ADDR_WIDTH * PARA_KERNEL;
  localparam int unsigned SAW = SRC_ADDR_WIDTH;
  localparam int unsigned SCW = SLICE_CNT_WIDTH;
  localparam int unsigned BW  = (PARA_KERNEL > 1) ? $clog2(PARA_KERNEL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FINISH} state_e;

  state_e         state_q, state_d;
  logic [SAW-1:0] ptr_q, ptr_d;
  logic [AW-1:0]  base_q, base_d;
  logic [SCW-1:0] count_q, count_d;
  logic [SCW-1:0] slice_q, slice_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [SW-1:0]  wdata_q, wdata_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           req_q, req_d;
  logic [SAW-1:0] raddr_q, raddr_d;
  logic           pend_q, pend_d;
  logic           upd_q;
  logic           fin_q, fin_d;
  logic           start_c;
  logic           upd_edge_c;
  logic           unused_upd_addr;

  assign unused_upd_addr = ^(update_weight_ram_addr >> AW);
  assign upd_edge_c      = update_weight_ram & ~upd_q;

  // Next-state logic: trigger arbitration, request sequencing and slice commit
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    count_d = count_q;
    slice_d = slice_q;
    beat_d  = beat_q;
    stage_d = stage_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    done_d  = done_q;
    busy_d  = busy_q;
    fin_d   = fin_q;
    req_d   = 1'b0;
    raddr_d = raddr_q;
    pend_d  = pend_q | upd_edge_c;
    start_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start && (load_slices != '0)) begin
          base_d  = load_addr;
          count_d = load_slices;
          ptr_d   = load_src_addr;
          start_c = 1'b1;
        end else if (pend_d) begin
          base_d  = update_weight_ram_addr[AW-1:0];
          count_d = SCW'(UPDATE_SLICES);
          pend_d  = 1'b0;
          start_c = 1'b1;
        end
        if (start_c) begin
          state_d = S_REQ;
          slice_d = '0;
          beat_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_REQ: begin
        ptr_d   = ptr_q + SAW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (src_rd_valid) begin
          for (int k = 0; k < int'(PARA_KERNEL); k++) begin
            if (beat_q == BW'(k)) stage_d[k*KW +: KW] = src_rd_data;
          end
          if (beat_q != BW'(PARA_KERNEL - 1)) begin
            beat_d  = beat_q + BW'(1);
            state_d = S_REQ;
          end else begin
            wdata_d = stage_d;
            waddr_d = base_q + AW'(slice_q);
            beat_d  = '0;
            slice_d = slice_q + SCW'(1);
            if (slice_q == count_q - SCW'(1)) begin
              state_d = S_FINISH;
              fin_d   = 1'b0;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_FINISH: begin
        // One extra hold cycle with done low before completion is flagged
        if (!fin_q) begin
          fin_d = 1'b1;
        end else begin
          fin_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_REQ) begin
      req_d   = 1'b1;
      raddr_d = ptr_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      base_q  <= '0;
      count_q <= '0;
      slice_q <= '0;
      beat_q  <= '0;
      stage_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      raddr_q <= '0;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      count_q <= count_d;
      slice_q <= slice_d;
      beat_q  <= beat_d;
      stage_q <= stage_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      raddr_q <= raddr_d;
      pend_q  <= pend_d;
      upd_q   <= update_weight_ram;
      fin_q   <= fin_d;
    end
  end

  assign src_rd_req             = req_q;
  assign src_rd_addr            = raddr_q;
  assign weight_data            = wdata_q;
  assign write_weight_data_addr = WAW'(waddr_q);
  assign weight_data_done       = done_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_weight_update_feeder.sv
// Bench for weight_update_feeder: expected reads and slice commits are queued at
// issue time and popped by a monitor; a source-memory model answers with variable latency.
`timescale 1ns/1ps
module tb_weight_update_feeder;

  localparam int unsigned DW  = 16;
  localparam int unsigned KS  = 3;
  localparam int unsigned K2  = KS * KS;
  localparam int unsigned KW  = K2 * DW;
  localparam int unsigned PK  = 2;
  localparam int unsigned SW  = KW * PK;
  localparam int unsigned AW  = 10;
  localparam int unsigned WAW = AW * PK;
  localparam int unsigned SAW = 16;
  localparam int unsigned US  = 2;
  localparam int unsigned SCW = 8;

  logic           clk;
  logic           rst;
  logic           load_start;
  logic [AW-1:0]  load_addr;
  logic [SCW-1:0] load_slices;
  logic [SAW-1:0] load_src_addr;
  logic           update_weight_ram;
  logic [WAW-1:0] update_weight_ram_addr;
  logic           src_rd_req;
  logic [SAW-1:0] src_rd_addr;
  logic           src_rd_valid;
  logic [KW-1:0]  src_rd_data;
  logic [SW-1:0]  weight_data;
  logic [WAW-1:0] write_weight_data_addr;
  logic           weight_data_done;
  logic           busy;

  weight_update_feeder #(
    .DATA_WIDTH(DW), .KERNEL_SIZE_MAX(KS), .PARA_KERNEL(PK),
    .WEIGHT_WRITE_ADDR_WIDTH(AW), .SRC_ADDR_WIDTH(SAW),
    .UPDATE_SLICES(US), .SLICE_CNT_WIDTH(SCW)
  ) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_addr(load_addr), .load_slices(load_slices),
    .load_src_addr(load_src_addr),
    .update_weight_ram(update_weight_ram), .update_weight_ram_addr(update_weight_ram_addr),
    .src_rd_req(src_rd_req), .src_rd_addr(src_rd_addr),
    .src_rd_valid(src_rd_valid), .src_rd_data(src_rd_data),
    .weight_data(weight_data), .write_weight_data_addr(write_weight_data_addr),
    .weight_data_done(weight_data_done), .busy(busy)
  );

  typedef struct {
    logic [SW-1:0] data;
    logic [AW-1:0] addr;
  } cmt_t;

  cmt_t           exp_cmt[$];
  logic [SAW-1:0] exp_req[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  longint         cyc = 0;
  longint         last_commit_cyc = 0;
  logic [DW-1:0]  salt [K2];
  int             lat_mode = 0;
  int             stray_req = 0;
  logic [SAW-1:0] mptr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source memory content: unique per kernel index, so every commit changes the outputs
  function automatic logic [KW-1:0] kern(input logic [SAW-1:0] a);
    logic [KW-1:0] r;
    for (int j = 0; j < int'(K2); j++) r[j*DW +: DW] = a ^ salt[j];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: slice s holds kernels src+s*PK+k in field k, written at base+s
  task automatic expect_burst(input logic [AW-1:0] base, input int n, input logic [SAW-1:0] src);
    cmt_t           c;
    logic [SAW-1:0] a;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < int'(PK); k++) begin
        a = src + SAW'(s * int'(PK) + k);
        exp_req.push_back(a);
        c.data[k*KW +: KW] = kern(a);
      end
      c.addr = base + AW'(s);
      exp_cmt.push_back(c);
    end
  endtask

  task automatic start_check(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, 64'(busy), 64'(1));
    chk({nm, "_done_low"}, 64'(weight_data_done), 64'(0));
    chk({nm, "_first_req"}, 64'(src_rd_req), 64'(1));
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (weight_data_done) break;
    end
    if (i == 400) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: done still 0 after 400 cycles, expected 1", nm);
    end else begin
      chk({nm, "_done_lag"}, 64'(cyc - last_commit_cyc), 64'(2));
      chk({nm, "_busy_end"}, 64'(busy), 64'(0));
    end
  endtask

  task automatic issue_load(input logic [AW-1:0] base, input logic [SCW-1:0] n, input logic [SAW-1:0] src);
    @(posedge clk); #1;
    expect_burst(base, int'(n), src);
    mptr = src + SAW'(int'(n) * int'(PK));
    load_start = 1'b1; load_addr = base; load_slices = n; load_src_addr = src;
    @(posedge clk); #1;
    load_start = 1'b0;
    start_check("load");
  endtask

  task automatic issue_update(input logic [WAW-1:0] a);
    @(posedge clk); #1;
    expect_burst(a[AW-1:0], int'(US), mptr);
    mptr = mptr + SAW'(US * PK);
    update_weight_ram_addr = a; update_weight_ram = 1'b1;
    @(posedge clk); #1;
    start_check("upd");
  endtask

  // Source memory: answers each request after 1 or 1..5 cycles; injects stray valids when idle
  initial begin : responder
    int             cd;
    int             stray_done;
    logic [SAW-1:0] ra;
    cd = 0; stray_done = 0; ra = '0;
    src_rd_valid = 1'b0; src_rd_data = '0;
    forever begin
      @(negedge clk);
      if (src_rd_req) begin
        ra = src_rd_addr;
        cd = (lat_mode == 0) ? 1 : int'($urandom_range(1, 5));
      end
      @(posedge clk); #1;
      src_rd_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          src_rd_valid = 1'b1;
          src_rd_data  = kern(ra);
        end
      end else if (stray_req != stray_done) begin
        stray_done++;
        src_rd_valid = 1'b1;
        src_rd_data  = KW'({5{$urandom}});
      end
    end
  end

  // Monitor: pops expected reads and commits whenever the DUT presents them
  initial begin : monitor
    logic [SW-1:0] pd;
    logic [AW-1:0] pa;
    cmt_t          e;
    pd = '0; pa = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pd = weight_data; pa = write_weight_data_addr[AW-1:0];
      end else begin
        if (src_rd_req) begin
          if (exp_req.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_req: got addr 0x%0h, expected no request", src_rd_addr);
          end else begin
            chk("req_addr", 64'(src_rd_addr), 64'(exp_req.pop_front()));
          end
        end
        if (weight_data !== pd || write_weight_data_addr[AW-1:0] !== pa) begin
          last_commit_cyc = cyc;
          n_tests++;
          if (exp_cmt.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_commit: got addr 0x%0h, expected no commit", write_weight_data_addr);
          end else begin
            e = exp_cmt.pop_front();
            if (weight_data !== e.data || write_weight_data_addr !== WAW'(e.addr)) begin
              n_fail++;
              $display("FAIL commit: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                       write_weight_data_addr, weight_data, e.addr, e.data);
            end
            chk("commit_done_low", 64'(weight_data_done), 64'(0));
          end
          pd = weight_data; pa = write_weight_data_addr[AW-1:0];
        end
      end
    end
  end

  initial begin : stimulus
    int               i;
    int               op;
    logic [WAW-1:0]   ua;
    rst = 1'b1; load_start = 1'b0; load_addr = '0; load_slices = '0; load_src_addr = '0;
    update_weight_ram = 1'b0; update_weight_ram_addr = '0;
    for (int j = 0; j < int'(K2); j++) salt[j] = DW'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_weight_data", 64'(weight_data != '0), 64'(0));
    chk("rst_waddr", 64'(write_weight_data_addr), 64'(0));
    chk("rst_done", 64'(weight_data_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req", 64'(src_rd_req), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Basic load, fixed latency
    issue_load(AW'(0), SCW'(2), SAW'(0));
    wait_done("load");

    // Update request, level held high afterwards
    issue_update(WAW'({10'h155, 10'd27}));
    wait_done("update");
    repeat (20) @(negedge clk);
    chk("upd_hold_busy", 64'(busy), 64'(0));
    chk("upd_hold_done", 64'(weight_data_done), 64'(1));
    update_weight_ram = 1'b0;

    // Variable latency with stray valids
    lat_mode = 1;
    stray_req++;
    repeat (3) @(posedge clk);
    issue_load(AW'(0), SCW'(2), SAW'(0));
    stray_req += 2;
    wait_done("varlat");

    // Collision of load and update edge, then load ignored while busy
    repeat (2) @(posedge clk); #1;
    expect_burst(AW'(100), 3, SAW'(16'h0200));
    mptr = SAW'(16'h0206);
    expect_burst(AW'(600), int'(US), mptr);
    mptr = mptr + SAW'(US * PK);
    load_start = 1'b1; load_addr = AW'(100); load_slices = SCW'(3); load_src_addr = SAW'(16'h0200);
    update_weight_ram = 1'b1; update_weight_ram_addr = WAW'(600);
    @(posedge clk); #1 load_start = 1'b0;
    start_check("coll_load");
    wait_done("coll_load");
    start_check("coll_upd");
    repeat (3) @(posedge clk); #1;
    load_start = 1'b1; load_addr = AW'(9); load_slices = SCW'(2); load_src_addr = SAW'(16'h7777);
    @(posedge clk); #1 load_start = 1'b0;
    wait_done("coll_upd");
    update_weight_ram = 1'b0;

    // Reset after the first beat of a burst
    lat_mode = 0;
    issue_load(AW'(5), SCW'(2), SAW'(100));
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_rd_valid) break;
    end
    if (i == 50) begin
      n_tests++; n_fail++;
      $display("FAIL rst_wait_valid: no source valid within 50 cycles, expected one");
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wdata", 64'(weight_data != '0), 64'(0));
    chk("mid_rst_waddr", 64'(write_weight_data_addr), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_req", 64'(src_rd_req), 64'(0));
    chk("mid_rst_no_commit", 64'(exp_cmt.size()), 64'(2));
    exp_cmt.delete();
    exp_req.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    issue_load(AW'(5), SCW'(2), SAW'(100));
    wait_done("rst_reload");

    // Source pointer wrap, then a zero-slice load
    issue_load(AW'(7), SCW'(1), SAW'(16'hFFFF));
    wait_done("wrap");
    @(posedge clk); #1;
    load_start = 1'b1; load_addr = AW'(3); load_slices = SCW'(0); load_src_addr = SAW'(16'h1234);
    @(posedge clk); #1 load_start = 1'b0;
    @(negedge clk);
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_done", 64'(weight_data_done), 64'(1));
    repeat (5) @(negedge clk);
    chk("zero_busy_late", 64'(busy), 64'(0));

    // Randomised mix of loads and updates
    for (int n = 0; n < 8; n++) begin
      lat_mode = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) stray_req++;
      op = int'($urandom_range(0, 1));
      if (op == 0) begin
        issue_load(AW'($urandom), SCW'($urandom_range(1, 4)), SAW'($urandom));
        wait_done("rnd_load");
      end else begin
        ua = WAW'($urandom);
        issue_update(ua);
        wait_done("rnd_upd");
        @(posedge clk); #1 update_weight_ram = 1'b0;
      end
      repeat (2) @(posedge clk);
    end

    repeat (10) @(negedge clk);
    chk("req_queue_empty", 64'(exp_req.size()), 64'(0));
    chk("cmt_queue_empty", 64'(exp_cmt.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
